// File: rtl/regfile_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// regfile_ctrl_pkg
// Shared types and constants for the RegFile writeback arbiter slice.
//   REG_ADDR_W / REG_DATA_W : default register address and data widths
//   NUM_REGS                : number of architectural registers
//   wb_state_t              : controller state (post-reset clear, normal run)
//   wb_req_t                : one writeback request (destination + value)
// ---------------------------------------------------------------------------
package regfile_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef enum logic {
        INIT_CLR = 1'b0,
        RUN      = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the requester handshakes and the RegFile write port.
//   req_valid / req_addr / req_data : requester side, packed per requester
//   req_ready                       : one-hot grant back to the requesters
//   we0 / wr_addr0 / wr_din0        : registered RegFile write port
//   init_done                       : arbiter is accepting traffic
// Modports: master = requesters + RegFile side, slave = the arbiter.
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      we0;
    logic [ADDR_W-1:0]         wr_addr0;
    logic [DATA_W-1:0]         wr_din0;
    logic                      init_done;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, we0, wr_addr0, wr_din0, init_done
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, we0, wr_addr0, wr_din0, init_done
    );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
// Combinational one-hot grant among valid requesters plus the round-robin
// pointer register.
//   clk      : core clock
//   rst      : synchronous active-low reset (pointer returns to 0)
//   enable_i : arbiter may grant this cycle
//   valid_i  : per-requester pending write
//   grant_o  : one-hot grant, only ever set for a valid requester
// ARB_RR=1 searches from the pointer; ARB_RR=0 is fixed lowest-index priority
// and leaves the pointer parked at zero.
// ---------------------------------------------------------------------------
module wb_rr_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ARB_RR  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable_i,
    input  logic [NUM_REQ-1:0] valid_i,
    output logic [NUM_REQ-1:0] grant_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rrPtr_q;
    logic [PTR_W-1:0] rrPtr_d;
    logic [PTR_W-1:0] candidate;
    logic [PTR_W-1:0] gntIdx;
    logic             anyGrant;
    int               rotSum;

    // Walk the requesters once, starting at the pointer (or at 0 for fixed
    // priority), and grant the first valid one found.
    always_comb begin
        grant_o   = '0;
        gntIdx    = '0;
        anyGrant  = 1'b0;
        candidate = '0;
        rotSum    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ARB_RR != 0) begin
                rotSum = int'(rrPtr_q) + k;
                if (rotSum >= NUM_REQ) begin
                    rotSum = rotSum - NUM_REQ;
                end
                candidate = PTR_W'(rotSum);
            end else begin
                candidate = PTR_W'(k);
            end
            if (enable_i && !anyGrant && valid_i[candidate]) begin
                grant_o[candidate] = 1'b1;
                gntIdx             = candidate;
                anyGrant           = 1'b1;
            end
        end
    end

    // The requester after the winner gets first look next time.
    always_comb begin
        if (gntIdx == PTR_W'(NUM_REQ - 1)) begin
            rrPtr_d = '0;
        end else begin
            rrPtr_d = gntIdx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rrPtr_q <= '0;
        end else if ((ARB_RR != 0) && anyGrant) begin
            rrPtr_q <= rrPtr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single RegFile write port between NUM_REQ writeback requesters.
// The winning request is registered and presented on we0/wr_addr0/wr_din0 in
// the following cycle; writes to register 0 are consumed but not enabled.
//   clk : core clock, rising edge
//   rst : synchronous active-low reset
//   bus : regfile_wb_arbiter_if.slave (requester handshakes, write port,
//         init_done)
// Build option: define REGFILE_INIT_CLR_EN to zero every register after
// reset before any request is granted. Without it the block runs from the
// first cycle out of reset.
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int ARB_RR  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);

`ifdef REGFILE_INIT_CLR_EN
    localparam wb_state_t RESET_STATE = INIT_CLR;
`else
    localparam wb_state_t RESET_STATE = RUN;
`endif

    wb_state_t          state_q;
    wb_state_t          state_d;
    logic               we0_q;
    logic               we0_d;
    logic [ADDR_W-1:0]  wrAddr0_q;
    logic [ADDR_W-1:0]  wrAddr0_d;
    logic [DATA_W-1:0]  wrDin0_q;
    logic [DATA_W-1:0]  wrDin0_d;
`ifdef REGFILE_INIT_CLR_EN
    logic [ADDR_W-1:0]  clrCnt_q;
    logic [ADDR_W-1:0]  clrCnt_d;
`endif

    logic               runActive;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  selAddr;
    logic [DATA_W-1:0]  selData;

    // Grants are only offered in RUN and never while reset is held.
    assign runActive = rst && (state_q == RUN);

    wb_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ARB_RR  (ARB_RR)
    ) u_arb (
        .clk      (clk),
        .rst      (rst),
        .enable_i (runActive),
        .valid_i  (bus.req_valid),
        .grant_o  (grant)
    );

    // Pick the granted requester's slice out of the packed request buses.
    always_comb begin
        selAddr = '0;
        selData = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                selAddr = bus.req_addr[i*ADDR_W +: ADDR_W];
                selData = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state for the controller and the write-port register. A grant
    // always means a transfer because grants only go to valid requesters.
    always_comb begin
        state_d   = state_q;
        we0_d     = 1'b0;
        wrAddr0_d = wrAddr0_q;
        wrDin0_d  = wrDin0_q;
`ifdef REGFILE_INIT_CLR_EN
        clrCnt_d  = clrCnt_q;
`endif
        case (state_q)
`ifdef REGFILE_INIT_CLR_EN
            INIT_CLR: begin
                we0_d     = 1'b1;
                wrAddr0_d = clrCnt_q;
                wrDin0_d  = '0;
                clrCnt_d  = clrCnt_q + 1'b1;
                if (&clrCnt_q) begin
                    state_d = RUN;
                end
            end
`endif
            RUN: begin
                if (|grant) begin
                    we0_d     = (selAddr != '0);
                    wrAddr0_d = selAddr;
                    wrDin0_d  = selData;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RESET_STATE;
            we0_q     <= 1'b0;
            wrAddr0_q <= '0;
            wrDin0_q  <= '0;
`ifdef REGFILE_INIT_CLR_EN
            clrCnt_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            we0_q     <= we0_d;
            wrAddr0_q <= wrAddr0_d;
            wrDin0_q  <= wrDin0_d;
`ifdef REGFILE_INIT_CLR_EN
            clrCnt_q  <= clrCnt_d;
`endif
        end
    end

    // Masking the enable with rst drops a write that was accepted just
    // before reset, so RegFile never sees it.
    assign bus.req_ready = grant;
    assign bus.we0       = we0_q & rst;
    assign bus.wr_addr0  = wrAddr0_q;
    assign bus.wr_din0   = wrDin0_q;
    assign bus.init_done = runActive;

endmodule
